// File: rtl/filter_pkg.sv
// filter_pkg: shared FSM/mode enums and pixel helpers for face_filter_engine.
// Provides RGB565-to-gray conversion and the 3x3-window border predicate.
package filter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_e;

  typedef enum logic {
    MODE_BLUR  = 1'b0,
    MODE_SOBEL = 1'b1
  } mode_e;

  // Channels widened by bit replication, then (R + 2G + B) / 4.
  function automatic logic [7:0] rgb565_to_gray(
    input logic [15:0] px
  );
    logic [9:0] r8;
    logic [9:0] g8;
    logic [9:0] b8;
    logic [9:0] sum;
    r8  = {2'b00, px[15:11], px[15:13]};
    g8  = {2'b00, px[10:5], px[10:9]};
    b8  = {2'b00, px[4:0], px[4:2]};
    sum = r8 + (g8 << 1) + b8;
    return 8'(sum >> 2);
  endfunction

  function automatic logic is_border(
    input int cx,
    input int cy,
    input int w,
    input int h
  );
    return (cx == 0) || (cx == w - 1) ||
           (cy == 0) || (cy == h - 1);
  endfunction

endpackage

// File: rtl/line_buffer.sv
// line_buffer: one image row of 8-bit gray, read-then-write each cycle.
// Ports: clk, we_i, addr_i, wdata_i in; rdata_o (old contents) out.
module line_buffer
  import filter_pkg::*;
#(
  parameter int DEPTH = 160,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  // Read sees the value stored before this cycle's write.
  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

endmodule

// File: rtl/face_filter_engine.sv
// face_filter_engine: streams a frame, applies 3x3 blur or Sobel on gray.
// Ports: clk, reset (async, low), start, mode in; busy, done out;
//   rd_en/rd_addr out, rd_data in (RGB565, 1-cycle latency);
//   out_we/out_addr/out_data out (RGB444 gray).
// Macro FACE_FILTER_THRESH_EN: binarize Sobel against EDGE_THRESH.
module face_filter_engine
  import filter_pkg::*;
#(
  parameter int IMG_WIDTH   = 160,
  parameter int IMG_HEIGHT  = 120,
  parameter int ADDR_WIDTH  = $clog2(IMG_WIDTH * IMG_HEIGHT),
  parameter int EDGE_THRESH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [15:0]           rd_data,
  output logic                  out_we,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [11:0]           out_data
);

  localparam int N  = IMG_WIDTH * IMG_HEIGHT;
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(N - 1);
  localparam logic [ADDR_WIDTH-1:0] LAG =
    ADDR_WIDTH'(IMG_WIDTH + 1);
  localparam logic [XW-1:0] XLAST =
    XW'(IMG_WIDTH - 1);

  state_e                state_q;
  mode_e                 mode_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  rd_en_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [XW-1:0]         rd_x_q;
  logic [YW-1:0]         rd_y_q;
  logic                  out_we_q;
  logic [ADDR_WIDTH-1:0] out_addr_q;
  logic [11:0]           out_data_q;

  logic                  v1_q;
  logic [ADDR_WIDTH-1:0] a1_q;
  logic [XW-1:0]         x1_q;
  logic [YW-1:0]         y1_q;
  logic                  v2_q;
  logic [ADDR_WIDTH-1:0] c2_q;
  logic                  bord2_q;

  logic [7:0] win_q [3][3];

  logic [7:0]  gray1;
  logic [7:0]  lb_mid;
  logic [7:0]  lb_top;
  int          cx1;
  int          cy1;
  logic        bord1;

  logic [11:0]        blur_acc;
  logic [7:0]         blur8;
  logic [9:0]         sx_l;
  logic [9:0]         sx_r;
  logic [9:0]         sy_t;
  logic [9:0]         sy_b;
  logic signed [10:0] gx;
  logic signed [10:0] gy;
  logic [10:0]        ax;
  logic [10:0]        ay;
  logic [11:0]        mag;
  logic [7:0]         sob8;
  logic [7:0]         res8;
  logic [11:0]        res_d;

  assign gray1 = rgb565_to_gray(rd_data);

  // lb0 holds the previous row, lb1 the row before it.
  line_buffer #(
    .DEPTH (IMG_WIDTH)
  ) u_lb0 (
    .clk     (clk),
    .we_i    (v1_q),
    .addr_i  (x1_q),
    .wdata_i (gray1),
    .rdata_o (lb_mid)
  );

  line_buffer #(
    .DEPTH (IMG_WIDTH)
  ) u_lb1 (
    .clk     (clk),
    .we_i    (v1_q),
    .addr_i  (x1_q),
    .wdata_i (lb_mid),
    .rdata_o (lb_top)
  );

  // Center sits one row up and one column left of the arriving pixel;
  // at x == 0 it wraps to the last column of the row above.
  always_comb begin
    cx1 = (x1_q == '0) ? IMG_WIDTH - 1 : int'(x1_q) - 1;
    cy1 = (x1_q == '0) ? int'(y1_q) - 2 : int'(y1_q) - 1;
    bord1 = is_border(cx1, cy1, IMG_WIDTH, IMG_HEIGHT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q    <= 1'b0;
      a1_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      v2_q    <= 1'b0;
      c2_q    <= '0;
      bord2_q <= 1'b0;
    end else begin
      v1_q    <= rd_en_q;
      a1_q    <= rd_addr_q;
      x1_q    <= rd_x_q;
      y1_q    <= rd_y_q;
      v2_q    <= v1_q && (a1_q >= LAG);
      c2_q    <= a1_q - LAG;
      bord2_q <= bord1;
    end
  end

  always_ff @(posedge clk) begin
    if (v1_q) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= lb_top;
      win_q[1][2] <= lb_mid;
      win_q[2][2] <= gray1;
    end
  end

  always_comb begin
    blur_acc = 12'(win_q[0][0]) + 12'(win_q[0][2])
             + 12'(win_q[2][0]) + 12'(win_q[2][2])
             + (12'(win_q[0][1]) << 1)
             + (12'(win_q[1][0]) << 1)
             + (12'(win_q[1][2]) << 1)
             + (12'(win_q[2][1]) << 1)
             + (12'(win_q[1][1]) << 2);
    blur8 = 8'(blur_acc >> 4);

    sx_l = 10'(win_q[0][0]) + (10'(win_q[1][0]) << 1)
         + 10'(win_q[2][0]);
    sx_r = 10'(win_q[0][2]) + (10'(win_q[1][2]) << 1)
         + 10'(win_q[2][2]);
    sy_t = 10'(win_q[0][0]) + (10'(win_q[0][1]) << 1)
         + 10'(win_q[0][2]);
    sy_b = 10'(win_q[2][0]) + (10'(win_q[2][1]) << 1)
         + 10'(win_q[2][2]);

    gx  = signed'({1'b0, sx_r}) - signed'({1'b0, sx_l});
    gy  = signed'({1'b0, sy_b}) - signed'({1'b0, sy_t});
    ax  = gx[10] ? 11'(-gx) : 11'(gx);
    ay  = gy[10] ? 11'(-gy) : 11'(gy);
    mag = 12'(ax) + 12'(ay);

`ifdef FACE_FILTER_THRESH_EN
    sob8 = (mag >= 12'(EDGE_THRESH)) ? 8'hFF : 8'h00;
`else
    sob8 = (mag > 12'd255) ? 8'hFF : mag[7:0];
`endif

    res8  = (mode_q == MODE_SOBEL) ? sob8 : blur8;
    res_d = bord2_q ? 12'h000 : {3{4'(res8 >> 4)}};
  end

`ifndef FACE_FILTER_THRESH_EN
  logic unused_thresh;
  assign unused_thresh = ^12'(EDGE_THRESH);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      mode_q     <= MODE_BLUR;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      rd_x_q     <= '0;
      rd_y_q     <= '0;
      out_we_q   <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= 12'h000;
    end else begin
      done_q   <= 1'b0;
      out_we_q <= 1'b0;
      if (v2_q) begin
        out_we_q   <= 1'b1;
        out_addr_q <= c2_q;
        out_data_q <= res_d;
      end
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= READ;
            mode_q    <= mode_e'(mode);
            busy_q    <= 1'b1;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
            rd_x_q    <= '0;
            rd_y_q    <= '0;
          end
        end
        READ: begin
          if (rd_addr_q == LAST) begin
            rd_en_q <= 1'b0;
            state_q <= DRAIN;
          end else begin
            rd_addr_q <= rd_addr_q + 1'b1;
            if (rd_x_q == XLAST) begin
              rd_x_q <= '0;
              rd_y_q <= rd_y_q + 1'b1;
            end else begin
              rd_x_q <= rd_x_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          // Tail rows are all border; they follow the last
          // pipelined write so addresses stay ascending.
          if (!v1_q && !v2_q) begin
            if (out_we_q && out_addr_q == LAST) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              out_we_q   <= 1'b1;
              out_addr_q <= out_addr_q + 1'b1;
              out_data_q <= 12'h000;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_en    = rd_en_q;
  assign rd_addr  = rd_addr_q;
  assign out_we   = out_we_q;
  assign out_addr = out_addr_q;
  assign out_data = out_data_q;

endmodule
